instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core; sequences fetch, decode, execute, memory and writeback around the instruction decoder.
- Consumes the decoder's control flags and drives the datapath strobes: IR load, ALU start, memory request, regfile write and PC update.
- Raises a sticky trap on invalid or system instructions and on bus timeouts.

Parameters:
- ALU_LAT, 1: number of cycles alu_go is held in EXECUTE (1..15).
- BUS_TIMEOUT, 255: cycles without an ack before a bus trap (1..255, 8-bit counter).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous reset, active-high
- ifetch_req  out  1  instruction fetch request
- ifetch_ack  in  1  fetch data valid; IR is loaded this cycle
- inst_ld  out  1  IR load strobe
- dec_nreset  out  1  drives the decoder nreset; 0 forces all decoder outputs to 0
- rd_enc, rw, mem_en, ALU_en, is_jal, is_jalr, is_branch, is_fence, is_system, is_invalid  in  1 each  decoder outputs
- branch_taken  in  1  ALU compare result, valid in EXECUTE's last cycle
- alu_go  out  1  ALU enable
- mem_req  out  1  data memory request
- mem_we  out  1  1 = store
- mem_ack  in  1  data access complete
- rf_we  out  1  regfile write enable
- pc_we  out  1  PC update strobe
- pc_sel  out  1  0 = PC+4, 1 = jump/branch target
- trap  out  1  sticky trap flag
- trap_cause  out  2  0 invalid, 1 system, 2 mem timeout, 3 fetch timeout
- state  out  3  current state encoding
- cycle_cnt, instret_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5. Codes 6 and 7 go to TRAP with cause 0.
- Reset (asynchronous, any time, including mid-access): state=FETCH, all counters 0, trap=0, trap_cause=0, branch-taken latch 0. All strobes are 0 while reset is asserted.
- Strobes are combinational from state, counters and registered flags; no output is glitch-registered.
- FETCH:
  - ifetch_req=1, dec_nreset=0.
  - On ifetch_ack: inst_ld=1 in the same cycle, go to DECODE.
  - If no ack after BUS_TIMEOUT cycles: go to TRAP, cause 3.
- DECODE (exactly 1 cycle):
  - dec_nreset=1.
  - Priority: is_invalid -> TRAP cause 0; else is_system -> TRAP cause 1; else is_fence -> WRITEBACK; else EXECUTE.
- EXECUTE:
  - alu_go = ALU_en for ALU_LAT cycles, counted by a 4-bit counter.
  - Latch branch_taken in the last cycle.
  - Then: mem_en -> MEMORY, else WRITEBACK.
- MEMORY:
  - mem_req=1, mem_we=!rw, held stable until mem_ack.
  - On ack: go to WRITEBACK. mem_ack and timeout expiry in the same cycle: the ack wins.
  - Timeout -> TRAP cause 2.
  - A mem_ack outside MEMORY is ignored.
- WRITEBACK (1 cycle):
  - rf_we = rd_enc; pc_we=1.
  - pc_sel = is_jal | is_jalr | (is_branch & latched branch_taken).
  - Then FETCH.
- TRAP:
  - trap=1 and trap_cause held; all strobes 0; dec_nreset=0.
  - Only reset exits TRAP.
- The bus timeout counter clears on every state entry and saturates at BUS_TIMEOUT.
- Nominal latency for an ALU instruction with ALU_LAT=1 and a 1-cycle ack: FETCH 1 + DECODE 1 + EXECUTE 1 + WRITEBACK 1 = 4 cycles.
- A NOP (decoder forces zeros) takes the EXECUTE path with alu_go=0 and rf_we=0, and only advances the PC.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle outside reset and TRAP.
  - instret_cnt increments on each WRITEBACK cycle.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the counters are not built; both ports are tied to 0.

Test Plan:
- ADD, ifetch_ack on the 1st cycle, ALU_LAT=1 -> states 0,1,2,4,0; rf_we=1 for one cycle in WRITEBACK; pc_sel=0.
- LW, mem_ack 3 cycles after mem_req -> mem_req high for 3 cycles, mem_we=0, then rf_we=1; total 7 cycles.
- BEQ with branch_taken=1, then BEQ with branch_taken=0 -> rf_we=0 both times; pc_sel=1 then pc_sel=0.
- is_invalid=1 in DECODE -> trap=1, cause=0, state=5 held; asserting reset returns state=0, trap=0.
- BUS_TIMEOUT=4, SW with no mem_ack -> trap cause 2 exactly 4 cycles after MEMORY entry; with mem_ack on cycle 4 -> WRITEBACK, no trap.
- SEQ_PERF_CNT_EN defined, 3 back-to-back ADDs -> instret_cnt=3, cycle_cnt=12; reset asserted mid-MEMORY -> both counters 0, mem_req=0 immediately.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the RV32I core.
// Define SEQ_PERF_CNT_EN to build the cycle and retired-instruction counters.
module instr_sequencer #(
    parameter int unsigned ALU_LAT     = 1,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ifetch_req,
    input  logic        ifetch_ack,
    output logic        inst_ld,
    output logic        dec_nreset,
    input  logic        rd_enc,
    input  logic        rw,
    input  logic        mem_en,
    input  logic        ALU_en,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        is_branch,
    input  logic        is_fence,
    input  logic        is_system,
    input  logic        is_invalid,
    input  logic        branch_taken,
    output logic        alu_go,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_INVALID   = 2'd0,
        CAUSE_SYSTEM    = 2'd1,
        CAUSE_MEM_TMO   = 2'd2,
        CAUSE_FETCH_TMO = 2'd3
    } cause_t;

    localparam logic [7:0] TMO_MAX  = 8'(BUS_TIMEOUT);
    localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);
    localparam logic [3:0] ALU_LAST = 4'(ALU_LAT - 1);

    state_t      state_q;
    cause_t      cause_q;
    logic        trap_q;
    logic        br_taken_q;
    logic [7:0]  tmo_cnt;
    logic [3:0]  alu_cnt;
    logic [7:0]  tmo_sat;
    logic        tmo_expired;
    logic        alu_last;

    // tmo_cnt counts completed cycles in the current state; expiry flags the last allowed one.
    assign tmo_sat     = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 8'd1;
    assign tmo_expired = (tmo_cnt >= TMO_LAST);
    assign alu_last    = (alu_cnt == ALU_LAST);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            cause_q    <= CAUSE_INVALID;
            trap_q     <= 1'b0;
            br_taken_q <= 1'b0;
            tmo_cnt    <= 8'd0;
            alu_cnt    <= 4'd0;
        end else begin
            tmo_cnt <= tmo_sat;
            case (state_q)
                S_FETCH: begin
                    if (ifetch_ack) begin
                        state_q <= S_DECODE;
                        tmo_cnt <= 8'd0;
                    end else if (tmo_expired) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_FETCH_TMO;
                        tmo_cnt <= 8'd0;
                    end
                end
                S_DECODE: begin
                    tmo_cnt <= 8'd0;
                    if (is_invalid) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_INVALID;
                    end else if (is_system) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_SYSTEM;
                    end else if (is_fence) begin
                        state_q <= S_WRITEBACK;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (alu_last) begin
                        br_taken_q <= branch_taken;
                        alu_cnt    <= 4'd0;
                        tmo_cnt    <= 8'd0;
                        state_q    <= mem_en ? S_MEMORY : S_WRITEBACK;
                    end else begin
                        alu_cnt <= alu_cnt + 4'd1;
                    end
                end
                S_MEMORY: begin
                    // An ack in the expiry cycle still completes the access.
                    if (mem_ack) begin
                        state_q <= S_WRITEBACK;
                        tmo_cnt <= 8'd0;
                    end else if (tmo_expired) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_MEM_TMO;
                        tmo_cnt <= 8'd0;
                    end
                end
                S_WRITEBACK: begin
                    state_q <= S_FETCH;
                    tmo_cnt <= 8'd0;
                end
                S_TRAP: begin
                    trap_q <= 1'b1;
                end
                default: begin
                    state_q <= S_TRAP;
                    trap_q  <= 1'b1;
                    cause_q <= CAUSE_INVALID;
                    tmo_cnt <= 8'd0;
                end
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        ifetch_req = 1'b0;
        inst_ld    = 1'b0;
        dec_nreset = 1'b0;
        alu_go     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ifetch_req = 1'b1;
                    inst_ld    = ifetch_ack;
                end
                S_DECODE: begin
                    dec_nreset = 1'b1;
                end
                S_EXECUTE: begin
                    dec_nreset = 1'b1;
                    alu_go     = ALU_en;
                end
                S_MEMORY: begin
                    dec_nreset = 1'b1;
                    mem_req    = 1'b1;
                    mem_we     = !rw;
                end
                S_WRITEBACK: begin
                    dec_nreset = 1'b1;
                    rf_we      = rd_enc;
                    pc_we      = 1'b1;
                    pc_sel     = is_jal | is_jalr | (is_branch & br_taken_q);
                end
                default: ;
            endcase
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state      = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            if (state_q != S_TRAP) cycle_q <= cycle_q + 32'd1;
            if (state_q == S_WRITEBACK) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (ALU_LAT=1, BUS_TIMEOUT=4).
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifetch_req, ifetch_ack, inst_ld, dec_nreset;
    logic        rd_enc, rw, mem_en, alu_en, is_jal, is_jalr, is_branch, is_fence, is_system, is_invalid;
    logic        branch_taken, alu_go, mem_req, mem_we, mem_ack, rf_we, pc_we, pc_sel, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instret_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Flag order: rd_enc rw mem_en ALU_en jal jalr branch fence system invalid
    localparam logic [9:0] F_ADD   = 10'b1_0_0_1_0_0_0_0_0_0;
    localparam logic [9:0] F_LW    = 10'b1_1_1_1_0_0_0_0_0_0;
    localparam logic [9:0] F_SW    = 10'b0_0_1_1_0_0_0_0_0_0;
    localparam logic [9:0] F_BEQ   = 10'b0_0_0_1_0_0_1_0_0_0;
    localparam logic [9:0] F_JAL   = 10'b1_0_0_0_1_0_0_0_0_0;
    localparam logic [9:0] F_NOP   = 10'b0_0_0_0_0_0_0_0_0_0;
    localparam logic [9:0] F_FENCE = 10'b0_0_0_0_0_0_0_1_0_0;
    localparam logic [9:0] F_SYS   = 10'b0_0_0_0_0_0_0_0_1_0;
    localparam logic [9:0] F_INV   = 10'b0_0_0_0_0_0_0_0_1_1;

    instr_sequencer #(.ALU_LAT(1), .BUS_TIMEOUT(4)) u_dut (
        .clk(clk), .reset(reset),
        .ifetch_req(ifetch_req), .ifetch_ack(ifetch_ack), .inst_ld(inst_ld), .dec_nreset(dec_nreset),
        .rd_enc(rd_enc), .rw(rw), .mem_en(mem_en), .ALU_en(alu_en),
        .is_jal(is_jal), .is_jalr(is_jalr), .is_branch(is_branch), .is_fence(is_fence),
        .is_system(is_system), .is_invalid(is_invalid), .branch_taken(branch_taken),
        .alu_go(alu_go), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .trap(trap), .trap_cause(trap_cause),
        .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    task automatic set_flags(input logic [9:0] f);
        {rd_enc, rw, mem_en, alu_en, is_jal, is_jalr, is_branch, is_fence, is_system, is_invalid} = f;
    endtask

    task automatic do_reset();
        reset = 1'b1; ifetch_ack = 1'b0; mem_ack = 1'b0; branch_taken = 1'b0;
        set_flags(F_NOP);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_ifetch_req", 32'(ifetch_req), 0);
        check("rst_trap", 32'(trap), 0);
        check("rst_cause", 32'(trap_cause), 0);
        nc();
        reset = 1'b0;
    endtask

    task automatic fetch_decode(input logic [9:0] f);
        set_flags(f);
        ifetch_ack = 1'b1;
        #1;
        check("fetch_state", 32'(state), 0);
        check("fetch_req", 32'(ifetch_req), 1);
        check("fetch_inst_ld", 32'(inst_ld), 1);
        check("fetch_dec_nreset", 32'(dec_nreset), 0);
        nc();
        ifetch_ack = 1'b0;
        #1;
        check("dec_state", 32'(state), 1);
        check("dec_nreset", 32'(dec_nreset), 1);
        check("dec_inst_ld", 32'(inst_ld), 0);
        nc();
    endtask

    task automatic run_alu(input logic [9:0] f, input logic br, input logic e_alu,
                           input logic e_rf, input logic e_sel);
        fetch_decode(f);
        branch_taken = br;
        #1;
        check("exe_state", 32'(state), 2);
        check("exe_alu_go", 32'(alu_go), 32'(e_alu));
        check("exe_mem_req", 32'(mem_req), 0);
        nc();
        branch_taken = !br;
        #1;
        check("wb_state", 32'(state), 4);
        check("wb_rf_we", 32'(rf_we), 32'(e_rf));
        check("wb_pc_we", 32'(pc_we), 1);
        check("wb_pc_sel", 32'(pc_sel), 32'(e_sel));
        nc();
        branch_taken = 1'b0;
    endtask

    // ack_cycle 0 means the memory never acknowledges.
    task automatic run_mem(input logic [9:0] f, input int ack_cycle, input logic e_we, input logic e_rf);
        fetch_decode(f);
        #1;
        check("mexe_state", 32'(state), 2);
        nc();
        for (int i = 1; i <= 4; i++) begin
            mem_ack = (i == ack_cycle);
            #1;
            check("mem_state", 32'(state), 3);
            check("mem_req", 32'(mem_req), 1);
            check("mem_we", 32'(mem_we), 32'(e_we));
            nc();
            if (i == ack_cycle) break;
        end
        mem_ack = 1'b0;
        #1;
        if (ack_cycle != 0) begin
            check("mwb_state", 32'(state), 4);
            check("mwb_rf_we", 32'(rf_we), 32'(e_rf));
            check("mwb_trap", 32'(trap), 0);
            nc();
            #1;
            check("mwb_next_state", 32'(state), 0);
        end else begin
            check("mtmo_state", 32'(state), 5);
            check("mtmo_trap", 32'(trap), 1);
            check("mtmo_cause", 32'(trap_cause), 2);
            check("mtmo_mem_req", 32'(mem_req), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        run_alu(F_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
        run_alu(F_BEQ, 1'b1, 1'b1, 1'b0, 1'b1);
        run_alu(F_BEQ, 1'b0, 1'b1, 1'b0, 1'b0);
        run_alu(F_JAL, 1'b0, 1'b0, 1'b1, 1'b1);
        mem_ack = 1'b1;
        run_alu(F_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_ack = 1'b0;

        fetch_decode(F_FENCE);
        #1;
        check("fence_state", 32'(state), 4);
        check("fence_pc_we", 32'(pc_we), 1);
        nc();

        run_mem(F_LW, 3, 1'b0, 1'b1);
        run_mem(F_SW, 4, 1'b1, 1'b0);
        run_mem(F_SW, 0, 1'b1, 1'b0);
        mem_ack = 1'b1;
        nc(); nc();
        #1;
        check("trap_hold_state", 32'(state), 5);
        mem_ack = 1'b0;

        do_reset();
        fetch_decode(F_INV);
        #1;
        check("inv_state", 32'(state), 5);
        check("inv_trap", 32'(trap), 1);
        check("inv_cause", 32'(trap_cause), 0);
        check("inv_dec_nreset", 32'(dec_nreset), 0);
        ifetch_ack = 1'b1;
        nc(); nc();
        #1;
        check("inv_hold_state", 32'(state), 5);
        check("inv_hold_req", 32'(ifetch_req), 0);
        check("inv_hold_ld", 32'(inst_ld), 0);

        do_reset();
        fetch_decode(F_SYS);
        #1;
        check("sys_state", 32'(state), 5);
        check("sys_cause", 32'(trap_cause), 1);

        do_reset();
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("ftmo_wait_state", 32'(state), 0);
            nc();
        end
        #1;
        check("ftmo_state", 32'(state), 5);
        check("ftmo_cause", 32'(trap_cause), 3);

        do_reset();
        for (int i = 0; i < 3; i++) run_alu(F_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
`ifdef SEQ_PERF_CNT_EN
        check("perf_cycle", cycle_cnt, 12);
        check("perf_instret", instret_cnt, 3);
`else
        check("perf_cycle_off", cycle_cnt, 0);
        check("perf_instret_off", instret_cnt, 0);
`endif
        fetch_decode(F_LW);
        nc();
        #1;
        check("pre_rst_mem_req", 32'(mem_req), 1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_mem_req", 32'(mem_req), 0);
        check("midrst_state", 32'(state), 0);
        check("midrst_cycle", cycle_cnt, 0);
        check("midrst_instret", instret_cnt, 0);
        nc();
        reset = 1'b0;
        nc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
